// File: rtl/door_sequence_controller_if.sv
// ---------------------------------------------------------------------------
// door_sequence_controller_if
//   Groups the door sequencer's request inputs and its registered outputs.
//   master : the environment (buttons, sensors, weight block, motion ctrl)
//   slave  : the door_sequence_controller itself
//
//   Inputs to the controller:
//     arrive                 pulse, cabin stopped level at a floor
//     open_btn / close_btn   level, cabin door buttons
//     obstruction            level, door-edge sensor
//     weight_limit_exceeded  level, from the weight-limit block
//     depart_ack             pulse, motion controller took the grant
//   Outputs from the controller:
//     motor_open / motor_close  door motor strobes
//     door_open                 door fully open
//     door_pos[7:0]             modelled position, 0 = closed
//     depart_ok                 departure grant
//     overload_alarm, nudge     buzzers
//     state[2:0]                FSM state code for debug
// ---------------------------------------------------------------------------
interface door_sequence_controller_if;
  logic       arrive;
  logic       open_btn;
  logic       close_btn;
  logic       obstruction;
  logic       weight_limit_exceeded;
  logic       depart_ack;

  logic       motor_open;
  logic       motor_close;
  logic       door_open;
  logic [7:0] door_pos;
  logic       depart_ok;
  logic       overload_alarm;
  logic       nudge;
  logic [2:0] state;

  modport master (
    output arrive, open_btn, close_btn, obstruction, weight_limit_exceeded, depart_ack,
    input  motor_open, motor_close, door_open, door_pos, depart_ok, overload_alarm,
           nudge, state
  );

  modport slave (
    input  arrive, open_btn, close_btn, obstruction, weight_limit_exceeded, depart_ack,
    output motor_open, motor_close, door_open, door_pos, depart_ok, overload_alarm,
           nudge, state
  );
endinterface

// File: rtl/door_sequence_controller.sv
// ---------------------------------------------------------------------------
// door_sequence_controller
//   Per-cabin door sequencer. Opens the door on arrival, dwells, closes, and
//   grants departure only with the door fully closed and no overload.
//   Tracks a modelled door position (not a sensor) and a count of
//   button-caused reopens; once that count hits MAX_REOPEN the door is in
//   nudge mode and open_btn can no longer reverse a close.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    door_sequence_controller_if.slave (all request/status signals)
//
//   Parameters:
//     TRAVEL_CYCLES  cycles for a full open or close stroke (1..255)
//     HOLD_CYCLES    dwell with the door fully open before auto-close (1..255)
//     MAX_REOPEN     button-caused reopens before nudge mode
//
//   All outputs are registered: 1-bit outputs are decoded from the next
//   state and flopped, door_pos/state come straight from their registers.
// ---------------------------------------------------------------------------
module door_sequence_controller #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 32,
  parameter int unsigned MAX_REOPEN    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  door_sequence_controller_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);
  localparam logic [7:0]       TRAVEL = 8'(TRAVEL_CYCLES);
  localparam logic [7:0]       HOLD   = 8'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] MAXR   = CNT_W'(MAX_REOPEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OPENING  = 3'd1,
    S_HOLD     = 3'd2,
    S_CLOSING  = 3'd3,
    S_OVERLOAD = 3'd4,
    S_READY    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       pos_q, pos_d;
  logic [7:0]       tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic motor_open_q, motor_open_d;
  logic motor_close_q, motor_close_d;
  logic door_open_q, door_open_d;
  logic depart_ok_q, depart_ok_d;
  logic overload_q, overload_d;
  logic nudge_q, nudge_d;

  logic nudge_mode;
  logic btn_reopen;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pos_q         <= '0;
      tmr_q         <= '0;
      cnt_q         <= '0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      door_open_q   <= 1'b0;
      depart_ok_q   <= 1'b0;
      overload_q    <= 1'b0;
      nudge_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      tmr_q         <= tmr_d;
      cnt_q         <= cnt_d;
      motor_open_q  <= motor_open_d;
      motor_close_q <= motor_close_d;
      door_open_q   <= door_open_d;
      depart_ok_q   <= depart_ok_d;
      overload_q    <= overload_d;
      nudge_q       <= nudge_d;
    end
  end

  // ------------------------------------------------- next state / outputs
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    nudge_mode = (cnt_q >= MAXR);
    // open_btn only counts as a reopen request outside nudge mode
    btn_reopen = bus.open_btn && !nudge_mode;

    case (state_q)
      S_IDLE: begin
        pos_d = '0;
        if (bus.arrive) state_d = S_OPENING;
      end

      // The edge that lands on TRAVEL also moves to HOLD, so a stroke from
      // closed is exactly TRAVEL_CYCLES cycles of motor_open.
      S_OPENING: begin
        if (pos_q >= TRAVEL - 8'd1) begin
          pos_d   = TRAVEL;
          state_d = S_HOLD;
          tmr_d   = HOLD;
        end else begin
          pos_d = pos_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (bus.weight_limit_exceeded) begin
          state_d = S_OVERLOAD;
        end else if (bus.obstruction || bus.open_btn) begin
          tmr_d = HOLD;
        end else begin
          tmr_d = (tmr_q != 8'd0) ? tmr_q - 8'd1 : 8'd0;
          if (bus.close_btn || tmr_q <= 8'd1) state_d = S_CLOSING;
        end
      end

      // Timer and close_btn are frozen out; leaving always gives a full dwell.
      S_OVERLOAD: begin
        if (!bus.weight_limit_exceeded) begin
          state_d = S_HOLD;
          tmr_d   = HOLD;
        end
      end

      // Reversal keeps the current position. Only a button reversal is
      // counted; obstruction and overload reversals are safety reopens.
      S_CLOSING: begin
        if (bus.obstruction || bus.weight_limit_exceeded || btn_reopen) begin
          if (!bus.obstruction && !bus.weight_limit_exceeded && !nudge_mode)
            cnt_d = cnt_q + CNT_W'(1);
          if (pos_q >= TRAVEL) begin
            // still fully open: no stroke needed, dwell again
            state_d = S_HOLD;
            tmr_d   = HOLD;
          end else begin
            state_d = S_OPENING;
          end
        end else if (pos_q <= 8'd1) begin
          pos_d   = 8'd0;
          state_d = S_READY;
        end else begin
          pos_d = pos_q - 8'd1;
        end
      end

      // Overload beats depart_ack; a dropped ack is the motion controller's
      // to retry once the grant comes back.
      S_READY: begin
        if (bus.weight_limit_exceeded) begin
          state_d = S_OPENING;
        end else if (btn_reopen) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_OPENING;
        end else if (bus.depart_ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        pos_d   = '0;
        tmr_d   = '0;
        cnt_d   = '0;
      end
    endcase

    motor_open_d  = (state_d == S_OPENING);
    motor_close_d = (state_d == S_CLOSING);
    door_open_d   = (state_d == S_HOLD) || (state_d == S_OVERLOAD);
    overload_d    = (state_d == S_OVERLOAD);
    depart_ok_d   = (state_d == S_READY);
    nudge_d       = (state_d == S_CLOSING) && (cnt_d >= MAXR);
  end

  assign bus.motor_open     = motor_open_q;
  assign bus.motor_close    = motor_close_q;
  assign bus.door_open      = door_open_q;
  assign bus.door_pos       = pos_q;
  assign bus.depart_ok      = depart_ok_q;
  assign bus.overload_alarm = overload_q;
  assign bus.nudge          = nudge_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_door_sequence_controller.sv
module tb_door_sequence_controller;
  localparam int T = 8;
  localparam int H = 32;
  localparam int M = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  door_sequence_controller_if bus();

  door_sequence_controller #(
    .TRAVEL_CYCLES(T), .HOLD_CYCLES(H), .MAX_REOPEN(M)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] pos;
    logic       mo;
    logic       mc;
    logic       dopen;
    logic       dok;
    logic       ovl;
    logic       ndg;
  } snap_t;

  snap_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: door phase (0 idle,1 opening,2 dwell,3 closing,
  // 4 overload,5 ready), position, dwell remaining and reopen count,
  // stepped straight from the behavioural rules.
  int m_ph = 0, m_pos = 0, m_tmr = 0, m_cnt = 0;

  task automatic model_step();
    bit wle, ob, obs;
    wle = bus.weight_limit_exceeded; ob = bus.open_btn; obs = bus.obstruction;
    if (!rst_n) begin
      m_ph = 0; m_pos = 0; m_tmr = 0; m_cnt = 0;
      return;
    end
    case (m_ph)
      0: if (bus.arrive) m_ph = 1;
      1: begin
        m_pos = m_pos + 1;
        if (m_pos >= T) begin m_pos = T; m_ph = 2; m_tmr = H; end
      end
      2: begin
        if (wle) m_ph = 4;
        else if (obs || ob) m_tmr = H;
        else begin
          m_tmr = m_tmr - 1;
          if (bus.close_btn || m_tmr <= 0) m_ph = 3;
        end
      end
      4: if (!wle) begin m_ph = 2; m_tmr = H; end
      3: begin
        if (obs || wle || (ob && m_cnt < M)) begin
          if (!obs && !wle) m_cnt = m_cnt + 1;
          if (m_pos == T) begin m_ph = 2; m_tmr = H; end
          else m_ph = 1;
        end else begin
          m_pos = m_pos - 1;
          if (m_pos <= 0) begin m_pos = 0; m_ph = 5; end
        end
      end
      5: begin
        if (wle) m_ph = 1;
        else if (ob && m_cnt < M) begin m_cnt = m_cnt + 1; m_ph = 1; end
        else if (bus.depart_ack) begin m_ph = 0; m_cnt = 0; end
      end
      default: m_ph = 0;
    endcase
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.st    = 3'(m_ph);
    s.pos   = 8'(m_pos);
    s.mo    = (m_ph == 1);
    s.mc    = (m_ph == 3);
    s.dopen = (m_ph == 2) || (m_ph == 4);
    s.dok   = (m_ph == 5);
    s.ovl   = (m_ph == 4);
    s.ndg   = (m_ph == 3) && (m_cnt == M);
    return s;
  endfunction

  // model advances on the same edge the DUT samples its inputs
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      exp_q.push_back(model_snap());
    end
  end

  // monitor: outputs are presented every cycle; compare away from the edge
  int cyc = 0;
  initial begin
    snap_t a, e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.st = bus.state; a.pos = bus.door_pos; a.mo = bus.motor_open;
        a.mc = bus.motor_close; a.dopen = bus.door_open; a.dok = bus.depart_ok;
        a.ovl = bus.overload_alarm; a.ndg = bus.nudge;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cyc%0d outputs: got st=%0d pos=%0d mo=%b mc=%b do=%b ok=%b ovl=%b ndg=%b required st=%0d pos=%0d mo=%b mc=%b do=%b ok=%b ovl=%b ndg=%b",
                   cyc, a.st, a.pos, a.mo, a.mc, a.dopen, a.dok, a.ovl, a.ndg,
                   e.st, e.pos, e.mo, e.mc, e.dopen, e.dok, e.ovl, e.ndg);
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic step(input bit a, input bit ob, input bit cb, input bit obs,
                      input bit wle, input bit ack);
    @(negedge clk);
    bus.arrive = a; bus.open_btn = ob; bus.close_btn = cb;
    bus.obstruction = obs; bus.weight_limit_exceeded = wle; bus.depart_ack = ack;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // drive for one edge, then let that edge pass so the model is current
  task automatic pulse(input bit a, input bit ob, input bit cb, input bit obs,
                       input bit wle, input bit ack);
    step(a, ob, cb, obs, wle, ack);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_for(input int ph, input int pos, input int budget, input string nm);
    int k = 0;
    while (!(m_ph == ph && (pos < 0 || m_pos == pos)) && k < budget) begin
      step(0, 0, 0, 0, 0, 0);
      k++;
    end
    if (!(m_ph == ph && (pos < 0 || m_pos == pos))) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_%s: got phase=%0d pos=%0d required phase=%0d pos=%0d within %0d cycles",
               nm, m_ph, m_pos, ph, pos, budget);
    end
  endtask

  initial begin
    bit wle_lvl;
    step(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // basic cycle: arrive at cycle 10
    idle(7);
    pulse(1, 0, 0, 0, 0, 0);
    wait_for(5, 0, 100, "basic_ready");
    idle(3);
    pulse(0, 0, 0, 0, 0, 1);
    wait_for(0, 0, 4, "basic_idle");
    idle(2);

    // obstruction reversal at pos 5 while closing
    pulse(1, 0, 0, 0, 0, 0);
    wait_for(3, 5, 100, "obs_pos5");
    pulse(0, 0, 0, 1, 0, 0);
    wait_for(5, 0, 150, "obs_ready");
    pulse(0, 0, 0, 0, 0, 1);
    idle(2);

    // overload during dwell, 50 cycles with close_btn pulses
    pulse(1, 0, 0, 0, 0, 0);
    wait_for(2, -1, 40, "ovl_hold");
    idle(4);
    for (int i = 0; i < 50; i++) step(0, 0, (i % 7) == 3, 0, 1, 0);
    wait_for(5, 0, 100, "ovl_ready");
    pulse(0, 0, 0, 0, 0, 1);
    idle(2);

    // nudge: three button reopens, fourth ignored, obstruction still reverses
    pulse(1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      wait_for(3, 4, 150, "nudge_close");
      pulse(0, 1, 0, 0, 0, 0);
    end
    wait_for(3, 2, 20, "nudge_pos2");
    pulse(0, 0, 0, 1, 0, 0);
    wait_for(5, 0, 150, "nudge_ready");
    pulse(0, 1, 0, 0, 0, 0);
    idle(2);
    pulse(0, 0, 0, 0, 0, 1);
    idle(2);

    // mid-stroke reset at pos 4 while opening
    pulse(1, 0, 0, 0, 0, 0);
    wait_for(1, 4, 20, "rst_pos4");
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(2);
    pulse(1, 0, 0, 0, 0, 0);
    wait_for(5, 0, 100, "rst_ready");
    pulse(0, 0, 0, 0, 0, 1);
    idle(2);

    // late overload: ack and weight together in READY
    pulse(1, 0, 0, 0, 0, 0);
    wait_for(5, 0, 100, "late_ready");
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    wait_for(5, 0, 150, "late_ready2");
    pulse(0, 0, 0, 0, 0, 1);
    idle(2);

    // randomized traffic
    wle_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) wle_lvl = ~wle_lvl;
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
           wle_lvl, $urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b1;
    idle(3);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
